// File: rtl/neopixel_pkg.sv
// Shared types and helpers for the neopixel frame sequencer.
// scale8() is only referenced when NEOPIXEL_BRIGHTNESS_EN is defined.
package neopixel_pkg;

    localparam int unsigned COLOR_W = 24;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        PRESENT = 2'd2,
        LATCH   = 2'd3
    } state_t;

    // Host stores {R,G,B}; the LEDs expect {G,R,B} on the wire.
    function automatic logic [COLOR_W-1:0] rgb_to_grb(input logic [COLOR_W-1:0] rgb);
        return {rgb[15:8], rgb[23:16], rgb[7:0]};
    endfunction

    function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] p;
        p = 16'(c) * (16'(b) + 16'd1);
        return p[15:8];
    endfunction

endpackage

// File: rtl/neopixel_frame_sequencer_if.sv
// Pixel stream from the frame sequencer to the bit serializer (valid/ready).
interface neopixel_frame_sequencer_if;

    logic [neopixel_pkg::COLOR_W-1:0] pixel_color;
    logic                             pixel_valid;
    logic                             pixel_ready;

    modport master (output pixel_color, output pixel_valid, input  pixel_ready);
    modport slave  (input  pixel_color, input  pixel_valid, output pixel_ready);

endinterface

// File: rtl/neopixel_pixel_ram.sv
// NUM_PIXELS x 24 simple dual-port RAM, registered read, read-before-write.
// No reset on the array or read register so it maps onto block RAM.
module neopixel_pixel_ram
    import neopixel_pkg::*;
#(
    parameter  int unsigned NUM_PIXELS = 16,
    parameter  int unsigned ADDR_W     = 8,
    localparam int unsigned RA_W       = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
    input  logic               clock,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [COLOR_W-1:0] wr_data,
    input  logic               rd_en,
    input  logic [RA_W-1:0]    rd_addr,
    output logic [COLOR_W-1:0] rd_data
);

    logic [COLOR_W-1:0] mem [NUM_PIXELS];
    logic               wr_ok;

    // Extra bit keeps the range check correct when NUM_PIXELS == 2**ADDR_W.
    assign wr_ok = wr_en && ({1'b0, wr_addr} < (ADDR_W + 1)'(NUM_PIXELS));

    always_ff @(posedge clock) begin
        if (wr_ok) begin
            mem[wr_addr[RA_W-1:0]] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/neopixel_frame_sequencer.sv
// Streams per-LED colours from the pixel RAM to the serializer, then enforces the latch gap.
// Optional NEOPIXEL_BRIGHTNESS_EN adds a brightness input that scales each channel.
module neopixel_frame_sequencer
    import neopixel_pkg::*;
#(
    parameter int unsigned NUM_PIXELS     = 16,
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned CLOCK_SPEED_HZ = 32_000_000,
    parameter int unsigned LATCH_US       = 80,
    parameter int unsigned REFRESH_HZ     = 60
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [COLOR_W-1:0]         wr_data,
    input  logic                       frame_start,
`ifdef NEOPIXEL_BRIGHTNESS_EN
    input  logic [7:0]                 brightness,
`endif
    neopixel_frame_sequencer_if.master pix,
    output logic                       busy,
    output logic [15:0]                frame_count
);

    localparam int unsigned LATCH_CYC   = CLOCK_SPEED_HZ / 1_000_000 * LATCH_US;
    localparam int unsigned LCNT_W      = $clog2(LATCH_CYC + 1);
    localparam int unsigned REFRESH_CYC = (REFRESH_HZ == 0) ? 1 : CLOCK_SPEED_HZ / REFRESH_HZ;
    localparam int unsigned RT_W        = $clog2(REFRESH_CYC + 1);
    localparam int unsigned RA_W        = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [LCNT_W-1:0]  latch_q;
    logic [RT_W-1:0]    refresh_q;
    logic               pending_q, pending_d;
    logic [COLOR_W-1:0] ram_q, color_q, present_color;
    logic               refresh_tick, trigger, handshake, last_px, latch_done;

    neopixel_pixel_ram #(
        .NUM_PIXELS (NUM_PIXELS),
        .ADDR_W     (ADDR_W)
    ) u_ram (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (state_d == READ),
        .rd_addr (idx_d[RA_W-1:0]),
        .rd_data (ram_q)
    );

    assign refresh_tick    = (REFRESH_HZ != 0) && (refresh_q == RT_W'(REFRESH_CYC - 1));
    assign trigger         = frame_start || refresh_tick;
    assign pix.pixel_valid = (state_q == PRESENT);
    assign pix.pixel_color = color_q;
    assign handshake       = pix.pixel_valid && pix.pixel_ready;
    assign last_px         = (idx_q == ADDR_W'(NUM_PIXELS - 1));
    assign busy            = (state_q != IDLE);

`ifdef NEOPIXEL_BRIGHTNESS_EN
    assign present_color = rgb_to_grb({scale8(ram_q[23:16], brightness),
                                       scale8(ram_q[15:8],  brightness),
                                       scale8(ram_q[7:0],   brightness)});
`else
    assign present_color = rgb_to_grb(ram_q);
`endif

    // The RAM read is launched on the edge entering READ, so its data is ready for the
    // READ->PRESENT colour register and the brightness scale adds no cycle.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pending_d  = pending_q || (trigger && (state_q != IDLE));
        latch_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (trigger || pending_q) begin
                    idx_d     = '0;
                    pending_d = 1'b0;
                    state_d   = READ;
                end
            end
            READ: state_d = PRESENT;
            PRESENT: begin
                if (handshake) begin
                    if (last_px) begin
                        state_d = LATCH;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = READ;
                    end
                end
            end
            LATCH: begin
                if (latch_q == LCNT_W'(LATCH_CYC - 1)) begin
                    latch_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            pending_q   <= 1'b0;
            latch_q     <= '0;
            refresh_q   <= '0;
            color_q     <= '0;
            frame_count <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            latch_q   <= ((state_q == LATCH) && !latch_done) ? latch_q + 1'b1 : '0;
            refresh_q <= (refresh_q == RT_W'(REFRESH_CYC - 1)) ? '0 : refresh_q + 1'b1;
            if (state_q == READ) begin
                color_q <= present_color;
            end
            if (latch_done) begin
                frame_count <= frame_count + 1'b1;
            end
        end
    end

endmodule
